mem_bus_arbiter: RTL

Two-master, one-slave arbiter that shares the SoC's single unified memory between the instruction-fetch port (I-cache refill) and the data port (D-cache / load-store). It sits between the core's cache controllers and the memory/peripheral interconnect inside Grande_Risco_5_SOC. It provides round-robin arbitration on contention, holds the grant until the slave completes, and generates a bus-error timeout.

---
 rtl/mem_bus_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave memory bus arbiter (I-fetch port vs. data port).
// Round-robin on contention, grant held to slave completion, bus-error timeout.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_rd,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    output logic                    i_err,

    input  logic                    d_rd,
    input  logic                    d_wr,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic                    d_err,

    output logic                    m_rd,
    output logic                    m_wr,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_ack
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]    state;
    logic          last_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    logic d_req;
    logic pick_i;
    logic pick_d;
    logic start_i;
    logic start_d;
    logic in_grant;
    logic tmo_hit;
    logic done_ok;
    logic done_tmo;

    // Arbitration and completion conditions; D wins a tie only if I owned the bus last
    always_comb begin
        d_req    = d_rd | d_wr;
        pick_d   = d_req & (~i_rd | ~last_d);
        pick_i   = i_rd & ~pick_d;
        start_i  = (state == S_IDLE) & pick_i;
        start_d  = (state == S_IDLE) & pick_d;
        in_grant = (state == S_GRANT_I) | (state == S_GRANT_D);
        cnt_inc  = cnt + CW'(1);
        tmo_hit  = TMO_EN && !m_ack && (cnt_inc == TMO);
        done_ok  = in_grant & m_ack;
        done_tmo = in_grant & tmo_hit;
    end

    // Main FSM: IDLE -> GRANT_x -> RESP -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state <= S_GRANT_I;
                    end else if (start_d) begin
                        state <= S_GRANT_D;
                    end
                end
                S_GRANT_I, S_GRANT_D: begin
                    if (done_ok || done_tmo) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Remember who owned the bus last so contention alternates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (start_i) begin
            last_d <= 1'b0;
        end else if (start_d) begin
            last_d <= 1'b1;
        end
    end

    // Wait counter: runs only while a granted access is unanswered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!in_grant) begin
            cnt <= '0;
        end else if (!m_ack) begin
            cnt <= cnt_inc;
        end
    end

    // Slave-side request: captured on grant, held until ack or timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else if (start_i) begin
            m_rd    <= 1'b1;
            m_wr    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else if (start_d) begin
            m_rd    <= ~d_wr;
            m_wr    <= d_wr;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wstrb <= d_wstrb;
        end else if (done_ok) begin
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
        end else if (done_tmo) begin
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end
    end

    // Instruction-port response: one-cycle ack, data only on a good read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
        end else if ((state == S_GRANT_I) && m_ack) begin
            i_ack   <= 1'b1;
            i_err   <= 1'b0;
            i_rdata <= m_rdata;
        end else if ((state == S_GRANT_I) && tmo_hit) begin
            i_ack   <= 1'b1;
            i_err   <= 1'b1;
            i_rdata <= '0;
        end else begin
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
        end
    end

    // Data-port response: writes return zero data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
        end else if ((state == S_GRANT_D) && m_ack) begin
            d_ack   <= 1'b1;
            d_err   <= 1'b0;
            d_rdata <= m_wr ? '0 : m_rdata;
        end else if ((state == S_GRANT_D) && tmo_hit) begin
            d_ack   <= 1'b1;
            d_err   <= 1'b1;
            d_rdata <= '0;
        end else begin
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
        end
    end

endmodule
